oam_dma_ram: RTL and testbench
==============================

# oam_dma_ram

Parametrised object-attribute RAM with an integrated OAM DMA engine, sitting on the GBC memory bus beside the other bus-mapped BRAM regions. It decodes its own address window and DMA trigger register, serves CPU reads and writes over the shared bidirectional data bus, and gives the PPU a dedicated read port. On a write to the DMA register it copies `DMA_LEN` bytes from `{value, 8'h00}` into the RAM, blocking CPU and PPU access while the copy runs.

## Interface
- `BASE_ADDR`, 16'hFE00, first bus address of the RAM window.
- `DEPTH`, 160, RAM size in bytes (1..256); the window is `[BASE_ADDR, BASE_ADDR+DEPTH)`.
- `DMA_REG_ADDR`, 16'hFF46, bus address of the DMA trigger/source register; must lie outside the window.
- `DMA_LEN`, 160, bytes per DMA transfer (1..`DEPTH`).

Ports:
- `I_MEM_CLK`  in  1  sole clock; all logic is rising-edge.
- `I_RESET`  in  1  synchronous, active-high reset.
- `I_ADDR`  in  16  CPU bus address.
- `IO_DATA`  inout  8  CPU bus data.
- `I_WE_L`  in  1  CPU write strobe, active low.
- `I_RE_L`  in  1  CPU read strobe, active low.
- `O_DMA_ADDR`  out  16  DMA source address.
- `O_DMA_RE_L`  out  1  DMA source read strobe, active low.
- `I_DMA_DATA`  in  8  DMA source data, valid one cycle after `O_DMA_RE_L` is sampled low.
- `O_DMA_BUSY`  out  1  high while a transfer is in progress.
- `I_PPU_ADDR`  in  8  PPU read index into the RAM.
- `O_PPU_DATA`  out  8  PPU read data, registered.

## Operation
- **Storage:** `DEPTH` x 8 array. Contents are not cleared by reset. Index = `I_ADDR - BASE_ADDR`.
- **Write detect:** `I_WE_L` is registered. A write fires once, on the first cycle `I_WE_L` is sampled low after being high. Holding the strobe low does not repeat the write.
- **CPU write, DMA idle:**
  - In-window address: write `IO_DATA` to the array.
  - `DMA_REG_ADDR`: latch `IO_DATA` into `dma_src`, then start the DMA.
- **CPU write, DMA busy:**
  - In-window writes are ignored.
  - A write to `DMA_REG_ADDR` restarts the transfer: index returns to 0 and the new `dma_src` is used.
- **CPU read (`I_RE_L` low, `I_WE_L` high):**
  - In-window: `IO_DATA` drives the registered array data for the address sampled on the previous edge; returns 8'hFF while busy.
  - `DMA_REG_ADDR`: drives `dma_src`.
  - Any other address: `IO_DATA` is high-Z.
- **Strobe conflict:** if both strobes are low, the write takes effect and `IO_DATA` stays high-Z.
- **DMA FSM:**
  - IDLE: wait for a trigger; on trigger go to REQ.
  - REQ: `O_DMA_ADDR = {dma_src, idx}`, `O_DMA_RE_L = 0`; go to WR.
  - WR: `mem[idx] <= I_DMA_DATA`, `O_DMA_RE_L = 1`. If `idx == DMA_LEN-1` go to IDLE; otherwise increment `idx` and go to REQ.
  - `O_DMA_BUSY` = (state != IDLE).
  - `idx` is 8 bits and never wraps, since `DMA_LEN` ≤ 256.
  - `dma_src` = 8'hFF gives source FF00.. with no special handling.
- **PPU port:** `O_PPU_DATA <= mem[I_PPU_ADDR]` each cycle. It loads 8'hFF instead if `I_PPU_ADDR >= DEPTH` or the DMA is busy.
- **Reset:**
  - State goes to IDLE and any in-flight DMA is aborted; bytes already written are kept.
  - `O_DMA_BUSY` = 0, `O_DMA_RE_L` = 1, `O_DMA_ADDR` = 16'h0000, `O_PPU_DATA` = 8'h00, `dma_src` = 8'h00.
  - `IO_DATA` is high-Z and the write-detect register is set to 1.

## Timing
- **CPU read:** 1-cycle latency from address and `I_RE_L` sampled to `IO_DATA` valid. `IO_DATA` tracks the address with that lag while `I_RE_L` stays low.
- **CPU write:** array updated at the edge where the falling `I_WE_L` is detected.
- **DMA start:** trigger edge T puts the FSM in REQ, so `O_DMA_BUSY` = 1 and `O_DMA_RE_L` = 0 from T+1.
- **DMA pacing:** 2 cycles per byte; byte n is written at edge T+2n+2.
- **DMA end:** `O_DMA_BUSY` falls at T+2·`DMA_LEN`+1.
- **PPU read:** 1-cycle latency.
- **Restart:** a trigger detected in any busy state takes effect at the next edge, entering REQ with `idx` = 0.

## Test plan
- Reset, then CPU writes A5 to FE00 and 3C to FE9F and reads both back → 1 cycle after each read is sampled, `IO_DATA` = A5 and 3C; a read of FEA0 leaves `IO_DATA` high-Z.
- Write 12 to FF46 with a source model returning low-byte XOR 8'h5A → `O_DMA_ADDR` steps 1200..129F, busy lasts exactly 320 cycles, and PPU reads of index 0/159 afterwards return 5A/C5.
- During DMA, CPU writes FE10 and reads FE10, FF46; PPU reads index 5 → the write is dropped, FE10 reads FF, FF46 reads 12, `O_PPU_DATA` = FF.
- Hold `I_WE_L` low for 10 cycles at FF46 → exactly one transfer runs; rewrite FF46 with 34 mid-transfer → `idx` restarts at 0 with source 3400.
- Assert `I_RESET` mid-DMA at byte 50 → next cycle busy = 0 and `O_DMA_RE_L` = 1; bytes 0..49 hold DMA data and byte 50+ keeps its old contents.
- `DEPTH`=256, `DMA_LEN`=256 instance → transfer covers index 00..FF with no wrap, and busy = 512 cycles.

Source files
------------

// File: rtl/oam_dma_ram.sv
// Object-attribute RAM on the GBC memory bus with an integrated OAM DMA engine.
// CPU gets a bus-mapped window plus DMA trigger register; PPU gets a registered read port.
module oam_dma_ram #(
  parameter logic [15:0] BASE_ADDR    = 16'hFE00,
  parameter int          DEPTH        = 160,
  parameter logic [15:0] DMA_REG_ADDR = 16'hFF46,
  parameter int          DMA_LEN      = 160
) (
  input  logic        I_MEM_CLK,
  input  logic        I_RESET,
  input  logic [15:0] I_ADDR,
  inout  wire  [7:0]  IO_DATA,
  input  logic        I_WE_L,
  input  logic        I_RE_L,
  output logic [15:0] O_DMA_ADDR,
  output logic        O_DMA_RE_L,
  input  logic [7:0]  I_DMA_DATA,
  output logic        O_DMA_BUSY,
  input  logic [7:0]  I_PPU_ADDR,
  output logic [7:0]  O_PPU_DATA
);

  typedef enum logic [1:0] {S_IDLE, S_REQ, S_WR} state_t;

  localparam logic [7:0] LAST_IDX = 8'(DMA_LEN - 1);

  state_t      state, state_nxt;
  logic [7:0]  mem [DEPTH];
  logic [7:0]  idx, idx_nxt;
  logic [7:0]  dma_src;
  logic        we_q;
  logic [15:0] win_off;
  logic        in_win, is_reg, wr_fire, trig, busy, ppu_oor;
  logic [7:0]  ppu_val;
  logic [7:0]  rd_data_p0;
  logic        rd_win_vld_p0, rd_reg_vld_p0;

  assign win_off    = I_ADDR - BASE_ADDR;
  assign in_win     = win_off < 16'(DEPTH);
  assign is_reg     = I_ADDR == DMA_REG_ADDR;
  // Falling edge of the registered write strobe: one write per strobe assertion.
  assign wr_fire    = we_q & ~I_WE_L;
  assign trig       = wr_fire & is_reg;
  assign busy       = state != S_IDLE;
  assign O_DMA_BUSY = busy;
  assign ppu_oor    = {1'b0, I_PPU_ADDR} >= 9'(DEPTH);
  assign ppu_val    = (ppu_oor | busy) ? 8'hFF : mem[I_PPU_ADDR];

  always_comb begin
    state_nxt  = state;
    idx_nxt    = idx;
    O_DMA_RE_L = 1'b1;
    O_DMA_ADDR = 16'h0000;
    case (state)
      S_IDLE: ;
      S_REQ: begin
        O_DMA_RE_L = 1'b0;
        O_DMA_ADDR = {dma_src, idx};
        state_nxt  = S_WR;
      end
      S_WR: begin
        if (idx == LAST_IDX) begin
          state_nxt = S_IDLE;
        end else begin
          idx_nxt   = idx + 8'd1;
          state_nxt = S_REQ;
        end
      end
      default: state_nxt = S_IDLE;
    endcase
    // A trigger from any state (re)starts the copy from byte 0.
    if (trig) begin
      state_nxt = S_REQ;
      idx_nxt   = 8'd0;
    end
  end

  // Stage p0: control, strobe detect, read-valid flags and PPU output.
  always_ff @(posedge I_MEM_CLK) begin
    if (I_RESET) begin
      state         <= S_IDLE;
      idx           <= 8'd0;
      dma_src       <= 8'h00;
      we_q          <= 1'b1;
      rd_win_vld_p0 <= 1'b0;
      rd_reg_vld_p0 <= 1'b0;
      O_PPU_DATA    <= 8'h00;
    end else begin
      state         <= state_nxt;
      idx           <= idx_nxt;
      we_q          <= I_WE_L;
      if (trig) dma_src <= IO_DATA;
      rd_win_vld_p0 <= ~I_RE_L & I_WE_L & in_win;
      rd_reg_vld_p0 <= ~I_RE_L & I_WE_L & is_reg;
      O_PPU_DATA    <= ppu_val;
    end
  end

  always_ff @(posedge I_MEM_CLK) begin
    rd_data_p0 <= is_reg ? dma_src : (busy ? 8'hFF : mem[win_off[7:0]]);
  end

  // Array writes: DMA owns the array while busy; reset suppresses both writers.
  always_ff @(posedge I_MEM_CLK) begin
    if (!I_RESET) begin
      if (state == S_WR)
        mem[idx] <= I_DMA_DATA;
      else if (wr_fire && in_win && !busy)
        mem[win_off[7:0]] <= IO_DATA;
    end
  end

  // Release the bus immediately if a write strobe overlaps the read.
  assign IO_DATA = ((rd_win_vld_p0 | rd_reg_vld_p0) & I_WE_L) ? rd_data_p0 : 8'hzz;

endmodule

// File: tb/tb_oam_dma_ram.sv
// Bench for oam_dma_ram: CPU window, DMA trigger/restart/reset-abort, PPU port,
// plus a full-depth (256-byte) instance. Source model returns low address byte ^ 8'h5A.
module tb_oam_dma_ram;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  always #5 clk = ~clk;

  // Instance 1: default 160-byte configuration
  logic [15:0] addr = 16'h0000;
  logic        we_l = 1'b1, re_l = 1'b1;
  logic        io_en = 1'b0;
  logic [7:0]  io_drv = 8'h00;
  wire  [7:0]  io;
  logic [15:0] dma_addr;
  logic        dma_re_l, busy;
  logic [7:0]  dma_data = 8'h00;
  logic [7:0]  ppu_addr = 8'h00;
  logic [7:0]  ppu_data;

  assign io = io_en ? io_drv : 8'hzz;
  for (genvar g = 0; g < 8; g++) begin : g_pd
    pulldown (io[g]);
  end

  oam_dma_ram u_dut (
    .I_MEM_CLK(clk), .I_RESET(rst), .I_ADDR(addr), .IO_DATA(io),
    .I_WE_L(we_l), .I_RE_L(re_l), .O_DMA_ADDR(dma_addr), .O_DMA_RE_L(dma_re_l),
    .I_DMA_DATA(dma_data), .O_DMA_BUSY(busy), .I_PPU_ADDR(ppu_addr), .O_PPU_DATA(ppu_data)
  );

  // Instance 2: full 256-byte configuration
  logic [15:0] addr2 = 16'h0000;
  logic        we2_l = 1'b1;
  logic        io2_en = 1'b0;
  logic [7:0]  io2_drv = 8'h00;
  wire  [7:0]  io2;
  logic [15:0] dma_addr2;
  logic        dma_re2_l, busy2;
  logic [7:0]  dma_data2 = 8'h00;
  logic [7:0]  ppu_addr2 = 8'h00;
  logic [7:0]  ppu_data2;

  assign io2 = io2_en ? io2_drv : 8'hzz;

  oam_dma_ram #(.DEPTH(256), .DMA_LEN(256)) u_dut2 (
    .I_MEM_CLK(clk), .I_RESET(rst), .I_ADDR(addr2), .IO_DATA(io2),
    .I_WE_L(we2_l), .I_RE_L(1'b1), .O_DMA_ADDR(dma_addr2), .O_DMA_RE_L(dma_re2_l),
    .I_DMA_DATA(dma_data2), .O_DMA_BUSY(busy2), .I_PPU_ADDR(ppu_addr2), .O_PPU_DATA(ppu_data2)
  );

  // Source memory model and request logs
  logic [15:0] q1[$];
  logic [15:0] q2[$];
  always @(posedge clk) begin
    if (!dma_re_l) begin
      dma_data <= dma_addr[7:0] ^ 8'h5A;
      q1.push_back(dma_addr);
    end
    if (!dma_re2_l) begin
      dma_data2 <= dma_addr2[7:0] ^ 8'h5A;
      q2.push_back(dma_addr2);
    end
  end

  logic [7:0] ref_mem [256];
  int n_checks = 0;
  int n_pass = 0;

  task automatic cpu_write(input logic [15:0] a, input logic [7:0] d);
    @(negedge clk);
    addr = a; io_drv = d; io_en = 1'b1; we_l = 1'b0;
    @(negedge clk);
    we_l = 1'b1; io_en = 1'b0;
  endtask

  task automatic cpu_read(input logic [15:0] a, output logic [7:0] v);
    @(negedge clk);
    addr = a; re_l = 1'b0;
    @(negedge clk);
    v = io;
    re_l = 1'b1;
  endtask

  task automatic ppu_read(input logic [7:0] a, output logic [7:0] v);
    @(negedge clk);
    ppu_addr = a;
    @(negedge clk);
    v = ppu_data;
  endtask

  task automatic wait_idle(output int cyc);
    cyc = 0;
    while (busy && cyc < 5000) begin
      cyc++;
      @(negedge clk);
    end
  endtask

  task automatic test_reset;
    logic [7:0] v;
    rst = 1'b1;
    repeat (3) @(negedge clk);
    n_checks++;
    if (busy !== 1'b0 || dma_re_l !== 1'b1 || dma_addr !== 16'h0000 || ppu_data !== 8'h00)
      $display("FAIL reset_outputs busy=%b re_l=%b addr=%h ppu=%h want 0 1 0000 00",
               busy, dma_re_l, dma_addr, ppu_data);
    else n_pass++;
    n_checks++;
    if (io !== 8'h00) $display("FAIL reset_io_z io=%h want released (00)", io);
    else n_pass++;
    rst = 1'b0;
    cpu_read(16'hFF46, v);
    n_checks++;
    if (v !== 8'h00) $display("FAIL reset_dma_src got=%h want=00", v);
    else n_pass++;
  endtask

  task automatic test_cpu_rw;
    logic [7:0] v, d;
    int i;
    cpu_write(16'hFE00, 8'hA5); ref_mem[0] = 8'hA5;
    cpu_write(16'hFE9F, 8'h3C); ref_mem[159] = 8'h3C;
    cpu_read(16'hFE00, v);
    n_checks++;
    if (v !== 8'hA5) $display("FAIL rd_fe00 got=%h want=a5", v); else n_pass++;
    cpu_read(16'hFE9F, v);
    n_checks++;
    if (v !== 8'h3C) $display("FAIL rd_fe9f got=%h want=3c", v); else n_pass++;
    cpu_read(16'hFEA0, v);
    n_checks++;
    if (v !== 8'h00) $display("FAIL rd_fea0_z got=%h want released (00)", v); else n_pass++;
    for (int k = 0; k < 160; k++) begin
      d = 8'($urandom_range(1, 255));
      cpu_write(BASE_OF(k), d);
      ref_mem[k] = d;
    end
    for (int k = 0; k < 20; k++) begin
      i = $urandom_range(0, 159);
      cpu_read(BASE_OF(i), v);
      n_checks++;
      if (v !== ref_mem[i]) $display("FAIL rd_rand idx=%0d got=%h want=%h", i, v, ref_mem[i]);
      else n_pass++;
    end
    // both strobes low: write lands, bus stays released
    @(negedge clk);
    addr = 16'hFE20; io_drv = 8'h99; io_en = 1'b1; we_l = 1'b0; re_l = 1'b0;
    @(negedge clk);
    we_l = 1'b1; re_l = 1'b1; io_en = 1'b0;
    ref_mem[32] = 8'h99;
    cpu_read(16'hFE20, v);
    n_checks++;
    if (v !== 8'h99) $display("FAIL strobe_conflict got=%h want=99", v); else n_pass++;
    // holding the strobe low writes only once even if the data changes
    @(negedge clk);
    addr = 16'hFE21; io_drv = 8'h11; io_en = 1'b1; we_l = 1'b0;
    @(negedge clk); io_drv = 8'h22;
    @(negedge clk); we_l = 1'b1; io_en = 1'b0;
    ref_mem[33] = 8'h11;
    cpu_read(16'hFE21, v);
    n_checks++;
    if (v !== 8'h11) $display("FAIL write_once got=%h want=11", v); else n_pass++;
  endtask

  function automatic logic [15:0] BASE_OF(input int i);
    return 16'hFE00 + 16'(i);
  endfunction

  task automatic test_ppu;
    logic [7:0] v, a, e;
    for (int k = 0; k < 16; k++) begin
      a = (k < 4) ? 8'($urandom_range(160, 255)) : 8'($urandom_range(0, 159));
      e = (a >= 8'd160) ? 8'hFF : ref_mem[a];
      ppu_read(a, v);
      n_checks++;
      if (v !== e) $display("FAIL ppu_rand idx=%0d got=%h want=%h", a, v, e); else n_pass++;
    end
  endtask

  task automatic test_dma_basic;
    int cyc, bad;
    logic [7:0] v;
    q1.delete();
    cpu_write(16'hFF46, 8'h12);
    wait_idle(cyc);
    n_checks++;
    if (cyc !== 320) $display("FAIL dma_busy_len got=%0d want=320", cyc); else n_pass++;
    bad = 0;
    for (int i = 0; i < q1.size(); i++) if (q1[i] !== 16'h1200 + 16'(i)) bad++;
    n_checks++;
    if (q1.size() !== 160 || bad != 0)
      $display("FAIL dma_addr_seq count=%0d bad=%0d want count=160 bad=0", q1.size(), bad);
    else n_pass++;
    for (int i = 0; i < 160; i++) ref_mem[i] = 8'(i) ^ 8'h5A;
    ppu_read(8'd0, v);
    n_checks++;
    if (v !== 8'h5A) $display("FAIL dma_ppu0 got=%h want=5a", v); else n_pass++;
    ppu_read(8'd159, v);
    n_checks++;
    if (v !== 8'hC5) $display("FAIL dma_ppu159 got=%h want=c5", v); else n_pass++;
  endtask

  task automatic test_dma_access;
    int cyc;
    logic [7:0] v;
    cpu_write(16'hFF46, 8'h12);
    repeat (60) @(negedge clk);
    cpu_write(16'hFE10, 8'h77);
    cpu_read(16'hFE10, v);
    n_checks++;
    if (v !== 8'hFF) $display("FAIL busy_rd_win got=%h want=ff", v); else n_pass++;
    cpu_read(16'hFF46, v);
    n_checks++;
    if (v !== 8'h12) $display("FAIL busy_rd_reg got=%h want=12", v); else n_pass++;
    ppu_read(8'd5, v);
    n_checks++;
    if (v !== 8'hFF) $display("FAIL busy_ppu got=%h want=ff", v); else n_pass++;
    wait_idle(cyc);
    cpu_read(16'hFE10, v);
    n_checks++;
    if (v !== ref_mem[16]) $display("FAIL busy_wr_dropped got=%h want=%h", v, ref_mem[16]);
    else n_pass++;
  endtask

  task automatic test_hold_and_restart;
    int cyc, n, sz, bad;
    q1.delete();
    @(negedge clk);
    addr = 16'hFF46; io_drv = 8'h12; io_en = 1'b1; we_l = 1'b0;
    repeat (10) @(negedge clk);
    we_l = 1'b1; io_en = 1'b0;
    wait_idle(cyc);
    n_checks++;
    if (q1.size() !== 160) $display("FAIL hold_one_xfer reqs=%0d want=160", q1.size());
    else n_pass++;
    q1.delete();
    cpu_write(16'hFF46, 8'h12);
    n = 0;
    while (q1.size() < 30 && n < 1000) begin @(negedge clk); n++; end
    cpu_write(16'hFF46, 8'h34);
    wait_idle(cyc);
    sz = q1.size();
    n_checks++;
    if (n >= 1000 || sz < 161) $display("FAIL restart_reqs count=%0d want>=161", sz);
    else begin
      bad = 0;
      for (int i = 0; i < 160; i++) if (q1[sz - 160 + i] !== 16'h3400 + 16'(i)) bad++;
      if (bad != 0 || q1[sz - 161][15:8] !== 8'h12)
        $display("FAIL restart_seq bad=%0d prev=%h want bad=0 prev=12xx", bad, q1[sz - 161]);
      else n_pass++;
    end
  endtask

  task automatic test_reset_mid_dma;
    int n, bad;
    logic [7:0] d, v;
    for (int k = 0; k < 160; k++) begin
      d = 8'($urandom);
      cpu_write(BASE_OF(k), d);
      ref_mem[k] = d;
    end
    q1.delete();
    cpu_write(16'hFF46, 8'($urandom));
    n = 0;
    while (q1.size() < 50 && n < 1000) begin @(negedge clk); n++; end
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    n_checks++;
    if (n >= 1000 || busy !== 1'b0 || dma_re_l !== 1'b1)
      $display("FAIL reset_abort busy=%b re_l=%b want 0 1", busy, dma_re_l);
    else n_pass++;
    rst = 1'b0;
    for (int i = 0; i < 50; i++) ref_mem[i] = 8'(i) ^ 8'h5A;
    bad = 0;
    for (int i = 0; i < 160; i++) begin
      ppu_read(8'(i), v);
      if (v !== ref_mem[i]) begin
        bad++;
        $display("FAIL reset_keep idx=%0d got=%h want=%h", i, v, ref_mem[i]);
      end
    end
    n_checks++;
    if (bad == 0) n_pass++;
  endtask

  task automatic test_full_depth;
    int cyc, bad;
    logic [7:0] v;
    q2.delete();
    @(negedge clk);
    addr2 = 16'hFF46; io2_drv = 8'hAB; io2_en = 1'b1; we2_l = 1'b0;
    @(negedge clk);
    we2_l = 1'b1; io2_en = 1'b0;
    cyc = 0;
    while (busy2 && cyc < 5000) begin cyc++; @(negedge clk); end
    n_checks++;
    if (cyc !== 512) $display("FAIL full_busy_len got=%0d want=512", cyc); else n_pass++;
    bad = 0;
    for (int i = 0; i < q2.size(); i++) if (q2[i] !== 16'hAB00 + 16'(i)) bad++;
    n_checks++;
    if (q2.size() !== 256 || bad != 0)
      $display("FAIL full_addr_seq count=%0d bad=%0d want count=256 bad=0", q2.size(), bad);
    else n_pass++;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      ppu_addr2 = (k == 0) ? 8'h00 : (k == 1) ? 8'h80 : 8'hFF;
      @(negedge clk);
      v = ppu_data2;
      n_checks++;
      if (v !== (ppu_addr2 ^ 8'h5A))
        $display("FAIL full_ppu idx=%h got=%h want=%h", ppu_addr2, v, ppu_addr2 ^ 8'h5A);
      else n_pass++;
    end
  endtask

  initial begin
    test_reset();
    test_cpu_rw();
    test_ppu();
    test_dma_basic();
    test_dma_access();
    test_hold_and_restart();
    test_reset_mid_dma();
    test_full_depth();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end

endmodule
